// File: rtl/mcu_bus_receiver_pkg.sv
// Shared encodings for the MCU parallel bus: control byte layout, channel
// register indices and the word-assembly state type.
package fa201_bus_pkg;

    localparam int unsigned CTRL_CMD_BIT = 7;

    localparam logic [2:0] CMD_RESET_PHASE = 3'd0;
    localparam logic [2:0] CMD_LOAD_CH1    = 3'd1;
    localparam logic [2:0] CMD_ADD_CH1     = 3'd2;
    localparam logic [2:0] CMD_LOAD_CH2    = 3'd3;
    localparam logic [2:0] CMD_ADD_CH2     = 3'd4;

    localparam logic [2:0] REG_CH1_NEG_STEP  = 3'd0;
    localparam logic [2:0] REG_CH1_POS_STEP  = 3'd1;
    localparam logic [2:0] REG_CH1_PHASE_ADD = 3'd2;
    localparam logic [2:0] REG_CH1_CONTROL   = 3'd3;
    localparam logic [2:0] REG_CH2_NEG_STEP  = 3'd4;
    localparam logic [2:0] REG_CH2_POS_STEP  = 3'd5;
    localparam logic [2:0] REG_CH2_PHASE_ADD = 3'd6;
    localparam logic [2:0] REG_CH2_CONTROL   = 3'd7;

    localparam int unsigned REG_WIDTH = 48;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mcu_bus_receiver_strobe_synchroniser.sv
// Brings one active-low MCU strobe into the core clock domain, captures the
// bus byte while it is low and flags its release with a one-cycle event.
module strobe_synchroniser #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe_n,
    input  logic [7:0] data,
    output logic [7:0] captured,
    output logic       release_event
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   history;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync          <= '1;
            history       <= 1'b1;
            captured      <= '0;
            release_event <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], strobe_n};
            history       <= sync[SYNC_STAGES-1];
            release_event <= sync[SYNC_STAGES-1] & ~history;
            // Keep refreshing while low so the event sees the final stable byte.
            if (!sync[SYNC_STAGES-1])
                captured <= data;
        end
    end

endmodule

// File: rtl/mcu_bus_receiver.sv
// MCU 8-bit bus front end: decodes control bytes into command pulses and
// assembles MSB-first words committed atomically to eight 48-bit registers.
module mcu_bus_receiver
    import fa201_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WORD_BYTES  = 6
) (
    input  logic        i_main_clk,
    input  logic        i_reset,
    input  logic        i_data_strobe,
    input  logic        i_control_strobe,
    input  logic [7:0]  i_data,
    output logic [47:0] o_channel1_negative_signal_step,
    output logic [47:0] o_channel1_positive_signal_step,
    output logic [47:0] o_channel1_signal_phase_add,
    output logic [47:0] o_channel1_signal_control,
    output logic [47:0] o_channel2_negative_signal_step,
    output logic [47:0] o_channel2_positive_signal_step,
    output logic [47:0] o_channel2_signal_phase_add,
    output logic [47:0] o_channel2_signal_control,
    output logic        o_reset_signal_phase_registers,
    output logic        o_load_channel1_step_registers,
    output logic        o_add_channel1_signal_phase,
    output logic        o_load_channel2_step_registers,
    output logic        o_add_channel2_signal_phase
);

    localparam int unsigned      CNT_W = $clog2(WORD_BYTES + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORD_BYTES);

    logic [7:0]           ctrl_byte;
    logic                 ctrl_event;
    logic [7:0]           data_byte;
    logic                 data_event;
    logic                 unused_ctrl_bits;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [REG_WIDTH-1:0] staging;
    logic [2:0]           sel;
    logic [REG_WIDTH-1:0] regs [8];

    assign unused_ctrl_bits = ^ctrl_byte[6:3];

    strobe_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) ctrl_sync (
        .clk           (i_main_clk),
        .rst           (i_reset),
        .strobe_n      (i_control_strobe),
        .data          (i_data),
        .captured      (ctrl_byte),
        .release_event (ctrl_event)
    );

    strobe_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) data_sync (
        .clk           (i_main_clk),
        .rst           (i_reset),
        .strobe_n      (i_data_strobe),
        .data          (i_data),
        .captured      (data_byte),
        .release_event (data_event)
    );

    always_ff @(posedge i_main_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            count   <= '0;
            staging <= '0;
            sel     <= '0;
            for (int unsigned i = 0; i < 8; i++)
                regs[i] <= '0;
            o_reset_signal_phase_registers <= 1'b0;
            o_load_channel1_step_registers <= 1'b0;
            o_add_channel1_signal_phase    <= 1'b0;
            o_load_channel2_step_registers <= 1'b0;
            o_add_channel2_signal_phase    <= 1'b0;
        end else begin
            o_reset_signal_phase_registers <= 1'b0;
            o_load_channel1_step_registers <= 1'b0;
            o_add_channel1_signal_phase    <= 1'b0;
            o_load_channel2_step_registers <= 1'b0;
            o_add_channel2_signal_phase    <= 1'b0;

            // Commit uses the old selection even if a select byte lands this cycle.
            if (state == LOADING && count == FULL) begin
                regs[sel] <= staging;
                state     <= DONE;
            end

            if (ctrl_event) begin
                if (!ctrl_byte[CTRL_CMD_BIT]) begin
                    sel     <= ctrl_byte[2:0];
                    count   <= '0;
                    staging <= '0;
                    state   <= LOADING;
                end else begin
                    case (ctrl_byte[2:0])
                        CMD_RESET_PHASE: o_reset_signal_phase_registers <= 1'b1;
                        CMD_LOAD_CH1:    o_load_channel1_step_registers <= 1'b1;
                        CMD_ADD_CH1:     o_add_channel1_signal_phase    <= 1'b1;
                        CMD_LOAD_CH2:    o_load_channel2_step_registers <= 1'b1;
                        CMD_ADD_CH2:     o_add_channel2_signal_phase    <= 1'b1;
                        default: ;
                    endcase
                end
            end else if (data_event && state == LOADING && count != FULL) begin
                staging <= {staging[REG_WIDTH-9:0], data_byte};
                count   <= count + CNT_W'(1);
            end
        end
    end

    assign o_channel1_negative_signal_step = regs[REG_CH1_NEG_STEP];
    assign o_channel1_positive_signal_step = regs[REG_CH1_POS_STEP];
    assign o_channel1_signal_phase_add     = regs[REG_CH1_PHASE_ADD];
    assign o_channel1_signal_control       = regs[REG_CH1_CONTROL];
    assign o_channel2_negative_signal_step = regs[REG_CH2_NEG_STEP];
    assign o_channel2_positive_signal_step = regs[REG_CH2_POS_STEP];
    assign o_channel2_signal_phase_add     = regs[REG_CH2_PHASE_ADD];
    assign o_channel2_signal_control       = regs[REG_CH2_CONTROL];

endmodule

// File: tb/tb_mcu_bus_receiver.sv
// Directed bench for mcu_bus_receiver: register writes, command pulses,
// abandoned/excess loads, simultaneous strobes and asynchronous reset.
module tb_mcu_bus_receiver;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_n = 1'b1;
    logic        ctrl_n = 1'b1;
    logic [7:0]  data = 8'h00;

    logic [47:0] ch1_neg, ch1_pos, ch1_add, ch1_ctl;
    logic [47:0] ch2_neg, ch2_pos, ch2_add, ch2_ctl;
    logic        p_rst, p_ld1, p_add1, p_ld2, p_add2;
    logic [4:0]  pulses;
    logic [47:0] obs [8];
    logic [47:0] exp_regs [8];

    logic [4:0]  seen;
    int          first;
    int          width;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mcu_bus_receiver #(.SYNC_STAGES(SYNC), .WORD_BYTES(6)) dut (
        .i_main_clk                      (clk),
        .i_reset                         (rst),
        .i_data_strobe                   (data_n),
        .i_control_strobe                (ctrl_n),
        .i_data                          (data),
        .o_channel1_negative_signal_step (ch1_neg),
        .o_channel1_positive_signal_step (ch1_pos),
        .o_channel1_signal_phase_add     (ch1_add),
        .o_channel1_signal_control       (ch1_ctl),
        .o_channel2_negative_signal_step (ch2_neg),
        .o_channel2_positive_signal_step (ch2_pos),
        .o_channel2_signal_phase_add     (ch2_add),
        .o_channel2_signal_control       (ch2_ctl),
        .o_reset_signal_phase_registers  (p_rst),
        .o_load_channel1_step_registers  (p_ld1),
        .o_add_channel1_signal_phase     (p_add1),
        .o_load_channel2_step_registers  (p_ld2),
        .o_add_channel2_signal_phase     (p_add2)
    );

    assign pulses = {p_add2, p_ld2, p_add1, p_ld1, p_rst};
    assign obs[0] = ch1_neg;
    assign obs[1] = ch1_pos;
    assign obs[2] = ch1_add;
    assign obs[3] = ch1_ctl;
    assign obs[4] = ch2_neg;
    assign obs[5] = ch2_pos;
    assign obs[6] = ch2_add;
    assign obs[7] = ch2_ctl;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_reg%0d", tag, i), obs[i], exp_regs[i]);
    endtask

    // kind: 0 = data strobe, 1 = control strobe, 2 = both released together.
    // Records which pulses fired, first cycle after release, and pulse width.
    task automatic xfer(input int kind, input logic [7:0] b);
        @(negedge clk);
        data = b;
        if (kind != 0) ctrl_n = 1'b0;
        if (kind != 1) data_n = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        ctrl_n = 1'b1;
        data_n = 1'b1;
        seen  = '0;
        first = -1;
        width = 0;
        for (int n = 1; n <= SYNC + 6; n++) begin
            @(posedge clk);
            #1;
            if (|pulses) begin
                seen = seen | pulses;
                if (first < 0) first = n;
                width++;
            end
        end
    endtask

    task automatic write_word(input logic [7:0] sel, input logic [47:0] word);
        logic [47:0] w;
        w = word;
        xfer(1, sel);
        for (int i = 5; i >= 0; i--)
            xfer(0, w[i*8 +: 8]);
    endtask

    initial begin
        logic [7:0] cmds [5];
        cmds[0] = 8'h80; cmds[1] = 8'h81; cmds[2] = 8'h82; cmds[3] = 8'h83; cmds[4] = 8'h84;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;

        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset_pulses", {43'd0, pulses}, 48'd0);
        rst = 1'b0;

        // Data without any select after reset is ignored.
        for (int i = 0; i < 6; i++) xfer(0, 8'h55);
        check_all("no_select");

        // Basic write, with a check that five bytes alone change nothing.
        xfer(1, 8'h02);
        xfer(0, 8'h01); xfer(0, 8'h23); xfer(0, 8'h45); xfer(0, 8'h67); xfer(0, 8'h89);
        check_all("partial");
        xfer(0, 8'hAB);
        exp_regs[2] = 48'h0123456789AB;
        check_all("write2");

        // Command pulses: exact one-cycle width at release + SYNC + 2.
        for (int k = 0; k < 5; k++) begin
            xfer(1, cmds[k]);
            check($sformatf("cmd%0d_which", k), {43'd0, seen}, 48'd1 << k);
            check($sformatf("cmd%0d_delay", k), 48'(first), 48'(SYNC + 2));
            check($sformatf("cmd%0d_width", k), 48'(width), 48'd1);
        end
        xfer(1, 8'h87);
        check("cmd7_none", {43'd0, seen}, 48'd0);

        // Abandoned partial load on index 5, then a full write to index 6.
        xfer(1, 8'h05);
        xfer(0, 8'h11); xfer(0, 8'h22); xfer(0, 8'h33);
        write_word(8'h06, 48'hFFFFFFFFFFFF);
        exp_regs[6] = 48'hFFFFFFFFFFFF;
        check_all("abandon");

        // Excess byte after a completed word is ignored.
        write_word(8'h03, 48'hA1A2A3A4A5A6);
        exp_regs[3] = 48'hA1A2A3A4A5A6;
        check_all("write3");
        xfer(0, 8'h55);
        check_all("excess");

        // Simultaneous strobes: command fires, data byte not counted.
        xfer(1, 8'h00);
        xfer(0, 8'h10); xfer(0, 8'h20);
        xfer(2, 8'h80);
        check("both_pulse", {43'd0, seen}, 48'd1);
        xfer(0, 8'h30); xfer(0, 8'h40); xfer(0, 8'h50);
        check_all("both_pending");
        xfer(0, 8'h60);
        exp_regs[0] = 48'h102030405060;
        check_all("both_commit");

        // Reset in the middle of a load.
        xfer(1, 8'h01);
        xfer(0, 8'hDE); xfer(0, 8'hAD); xfer(0, 8'hBE); xfer(0, 8'hEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        check_all("rst_midload");
        @(negedge clk);
        rst = 1'b0;
        write_word(8'h01, 48'h0A0B0C0D0E0F);
        exp_regs[1] = 48'h0A0B0C0D0E0F;
        check_all("after_rst");

        // Reset while a command pulse is high.
        @(negedge clk);
        data = 8'h83;
        ctrl_n = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        ctrl_n = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        check("pulse_before_rst", {43'd0, pulses}, 48'h8);
        #2;
        rst = 1'b1;
        #1;
        check("pulse_after_rst", {43'd0, pulses}, 48'd0);
        exp_regs[1] = '0;
        check_all("rst_midpulse");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcu_bus_receiver.md
Name: mcu_bus_receiver

Overview:
- Front end between the MCU 8-bit parallel bus and the two awg channels; sits directly upstream of the awg step/phase/control inputs.
- Synchronises the asynchronous active-low data/control strobes into the core clock domain and decodes control bytes.
- Assembles multi-byte values MSB-first and commits them atomically to eight 48-bit channel registers.
- Emits single-cycle command pulses (phase reset, step load, phase add).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each strobe synchroniser (min 2).
- WORD_BYTES, 6, bytes per register write (48-bit registers).

Ports:
- i_main_clk  in  1  core clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data_strobe  in  1  async, active-low; data byte valid while low.
- i_control_strobe  in  1  async, active-low; control byte valid while low.
- i_data  in  8  MCU data bus.
- o_channel1_negative_signal_step, o_channel1_positive_signal_step, o_channel1_signal_phase_add, o_channel1_signal_control  out  48 each  register index 0..3.
- o_channel2_negative_signal_step, o_channel2_positive_signal_step, o_channel2_signal_phase_add, o_channel2_signal_control  out  48 each  register index 4..7.
- o_reset_signal_phase_registers, o_load_channel1_step_registers, o_add_channel1_signal_phase, o_load_channel2_step_registers, o_add_channel2_signal_phase  out  1 each  one-cycle command pulses.

Behaviour:
- Reset (async assert): all 48-bit outputs 0, all pulses 0, synchronisers held high (idle), state IDLE, byte count 0, staging register 0, selected index 0.
- Synchronisers: each strobe passes through SYNC_STAGES flops, then one history flop. An event fires on the synchronised rising edge (strobe release).
- Data capture: the byte register loads i_data every cycle that the synchronised strobe is low. On the event, the last captured value is used.
- MCU rules: i_data stable for the whole strobe-low time; strobe low ≥ SYNC_STAGES+2 clocks; high ≥ SYNC_STAGES+2 clocks.
- Control byte decode:
  - bit7=0: select register index bits[2:0]; byte count cleared; staging cleared; state becomes LOADING.
  - bit7=1: command bits[2:0]: 0 reset phase, 1 load ch1 step, 2 add ch1 phase, 3 load ch2 step, 4 add ch2 phase; 5-7 ignored.
  - A command does not change the state, selection or byte count.
- Command pulse timing: asserted on the cycle after the event, exactly one cycle wide. Pin release to pulse is SYNC_STAGES+2 clocks.
- State machine:
  - IDLE: data events ignored.
  - LOADING: each data event shifts the byte into the staging register LSB end (MSB-first) and increments the count. When the count reaches WORD_BYTES, the next cycle writes staging to the selected register and the state becomes DONE.
  - DONE: data events ignored until a new select control byte arrives.
- Atomicity: the target register changes only at commit, all 48 bits in one cycle. A partial load never alters any output.
- A select byte received while LOADING abandons the partial word (no commit) and restarts at count 0 for the new index.
- Simultaneous control and data events in the same cycle: the control event is processed and the data byte is discarded.
- Commit and command pulse in the same cycle are both performed. The command acts on the register value already present; the new value is visible one cycle later.
- Reset mid-load: partial word lost, all registers 0.
- Byte count is a 3-bit counter for the default parameters (width clog2(WORD_BYTES+1)); it never wraps past WORD_BYTES.

Decomposition:
- Shared package fa201_bus_pkg: control encodings (CTRL_CMD_BIT=7, CMD_RESET_PHASE=0, CMD_LOAD_CH1=1, CMD_ADD_CH1=2, CMD_LOAD_CH2=3, CMD_ADD_CH2=4), register index constants 0..7, and the state enum (IDLE, LOADING, DONE).
- One sub-module, strobe_synchroniser: synchroniser chain, byte capture and release-edge event output. Instantiated twice.

Test Plan:
- Write sequence: reset, control 0x02, data bytes 0x01,0x23,0x45,0x67,0x89,0xAB -> o_channel1_signal_phase_add = 0x0123456789AB one cycle after the 6th event; all other registers remain 0.
- Command decode: control 0x81 -> o_load_channel1_step_registers high exactly 1 cycle, SYNC_STAGES+2 clocks after strobe release; control 0x87 -> no pulse on any output.
- Abandoned load: control 0x05, 3 data bytes, then control 0x06 plus 6 bytes of 0xFF -> index 5 unchanged; o_channel2_signal_phase_add = 0xFFFFFFFFFFFF.
- Excess data: after a completed write to index 3, a 7th data byte 0x55 is ignored and the register is unchanged. A write with no prior select after reset changes nothing.
- Simultaneous strobes: release both strobes in the same clock with control 0x80 -> phase reset pulse fires and the data byte is discarded (count unchanged).
- Async reset asserted mid-load (after 4 bytes) and mid-pulse -> outputs 0 immediately; a following full 6-byte write commits correctly.
